iiitb_fifo_uart_tx: RTL
=======================

Name: iiitb_fifo_uart_tx

Overview:
Consumer end of the FIFO. Pops bytes from the FIFO read interface (read_Enable / sig_Empty / buffer_Output) whenever data is present and tx_Enable is high. Serialises each byte onto a single asynchronous line as a UART 8N1 frame.
Sits between the FIFO read side and the chip-level TX pin.

Parameters:
DATA_WIDTH, 8, width of each FIFO entry and of the serial payload per frame
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2); internal counter width is $clog2(CLKS_PER_BIT)

Ports:
clock  input  1  single system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_Enable  input  1  permits new pops; does not abort a frame in progress
sig_Empty  input  1  FIFO empty flag
buffer_Output  input  DATA_WIDTH  FIFO read data, valid the cycle after read_Enable
read_Enable  output  1  registered one-cycle pop strobe to FIFO
tx_Serial  output  1  serial line; idle high
tx_Busy  output  1  high in every state except IDLE
tx_Done  output  1  one-cycle pulse on the last clock of the stop bit

Behaviour:
- Reset (synchronous, active-high, one clock): state=IDLE, tx_Serial=1, read_Enable=0, tx_Busy=0, tx_Done=0, bit/baud counters=0, shift register=0.
- States: IDLE -> POP -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx_Serial=1. If tx_Enable && !sig_Empty, go to POP. sig_Empty and tx_Enable are sampled only here.
- POP: read_Enable=1 for exactly this one cycle, then go to LOAD. Never more than one pop per frame.
- LOAD: capture buffer_Output into the shift register at the end of the cycle, then go to START.
- START: tx_Serial=0 for CLKS_PER_BIT cycles.
- DATA: DATA_WIDTH bits, LSB first, each held for CLKS_PER_BIT cycles. Bit counter runs 0..DATA_WIDTH-1.
- STOP: tx_Serial=1 for CLKS_PER_BIT cycles. tx_Done=1 on the final cycle of STOP, then go to IDLE.
- Frame length, pin view: (DATA_WIDTH+2)*CLKS_PER_BIT cycles; +CLKS_PER_BIT when parity is enabled.
- Back-to-back frames: the minimum idle-high gap between a stop bit and the next start bit is 3 cycles (IDLE, POP, LOAD).
- tx_Enable falling mid-frame: the current frame completes; no new pop follows.
- Reset mid-frame: the line returns high on the next cycle. The popped byte is discarded, not re-read.
- All outputs are registered; tx_Serial must be glitch-free.
- Baud counter: reloads at each bit boundary; wraps at CLKS_PER_BIT-1.

Optional Feature:
Macro: IIITB_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It transmits even parity (XOR of the payload) for CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity logic; the frame is 8N1 only.

Decomposition:
- Package iiitb_uart_pkg holds the state enum (IDLE, POP, LOAD, START, DATA, PARITY, STOP), the default CLKS_PER_BIT, and the idle line level constant.
- One sub-module, iiitb_baud_tick: a counter with synchronous clear that emits a bit-boundary tick every CLKS_PER_BIT cycles. It is cleared whenever the state enters START.

Test Plan:
- Single byte: CLKS_PER_BIT=4, FIFO holds 0xA5, tx_Enable=1 -> exactly one read_Enable pulse. tx_Serial runs 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles, 40 cycles total. tx_Done pulses once; tx_Busy is high throughout.
- Back-to-back: FIFO holds 0x01,0x80,0xFF -> three frames, three pops. Idle-high gap between frames is exactly 3 cycles. sig_Empty rises after the 3rd pop; the block then stays in IDLE.
- Empty/gated: sig_Empty=1 for 100 cycles -> read_Enable never asserts, tx_Serial=1. With sig_Empty=0 and tx_Enable=0 -> no pop. When tx_Enable rises, the pop occurs 1 cycle later.
- tx_Enable drop: deassert tx_Enable during DATA of 0x3C -> the frame completes correctly and no further pop occurs.
- Reset mid-frame: assert reset during bit 3 of 0x55 -> tx_Serial=1, tx_Busy=0, read_Enable=0 next cycle. The next frame starts from a fresh pop.
- Parity (macro defined): 0xA5 -> parity bit 0. 0x07 -> parity bit 1. Frame length is 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/iiitb_fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// The PARITY state is only reachable when IIITB_UART_TX_PARITY_EN is defined.
package iiitb_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } uart_state_e;

    localparam int   DEFAULT_DATA_WIDTH   = 8;
    localparam int   DEFAULT_CLKS_PER_BIT = 16;
    localparam logic LINE_IDLE            = 1'b1;

endpackage

// File: rtl/iiitb_fifo_uart_tx_if.sv
// FIFO read side plus serial line bundle; the tx block takes the slave view,
// whoever feeds the FIFO and watches the pin takes the master view.
interface iiitb_fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_Enable;
    logic                  sig_Empty;
    logic [DATA_WIDTH-1:0] buffer_Output;
    logic                  read_Enable;
    logic                  tx_Serial;
    logic                  tx_Busy;
    logic                  tx_Done;

    modport master (
        output tx_Enable,
        output sig_Empty,
        output buffer_Output,
        input  read_Enable,
        input  tx_Serial,
        input  tx_Busy,
        input  tx_Done
    );

    modport slave (
        input  tx_Enable,
        input  sig_Empty,
        input  buffer_Output,
        output read_Enable,
        output tx_Serial,
        output tx_Busy,
        output tx_Done
    );
endinterface

// File: rtl/iiitb_fifo_uart_tx_baud_tick.sv
// Bit-period counter: tick marks the last cycle of a bit, tick_pre the cycle before it.
// Counts 0..CLKS_PER_BIT-1 and wraps; clear forces the next count to zero.
module iiitb_baud_tick
    import iiitb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic tick_pre
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick     = (cnt_q == LAST);
    // Lets the parent register a pulse that lines up with the tick cycle.
    assign tick_pre = !clear && (cnt_q == PRE);

endmodule

// File: rtl/iiitb_fifo_uart_tx.sv
// Pops one byte per frame from a FIFO and sends it as a UART 8N1 frame.
// Define IIITB_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for tx_Enable && !sig_Empty
// POP    | one-cycle read_Enable strobe to the FIFO
// LOAD   | FIFO data valid, captured into the shift register
// START  | start bit (low)
// DATA   | payload bits, LSB first
// PARITY | even parity of the payload (optional)
// STOP   | stop bit (high), tx_Done on its last cycle
module iiitb_fifo_uart_tx
    import iiitb_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clock,
    input  logic                 reset,
    iiitb_fifo_uart_tx_if.slave  bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  read_enable_q, read_enable_d;
    logic                  tx_serial_q, tx_serial_d;
    logic                  tx_busy_q, tx_busy_d;
    logic                  tx_done_q, tx_done_d;
    logic                  baud_clear, baud_tick, baud_tick_pre;
`ifdef IIITB_UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    iiitb_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clock    (clock),
        .reset    (reset),
        .clear    (baud_clear),
        .tick     (baud_tick),
        .tick_pre (baud_tick_pre)
    );

    // Bit timing restarts exactly at the start bit, whatever the free-running count was.
    assign baud_clear = (state_d == START) && (state_q != START);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            read_enable_q <= 1'b0;
            tx_serial_q   <= LINE_IDLE;
            tx_busy_q     <= 1'b0;
            tx_done_q     <= 1'b0;
`ifdef IIITB_UART_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            read_enable_q <= read_enable_d;
            tx_serial_q   <= tx_serial_d;
            tx_busy_q     <= tx_busy_d;
            tx_done_q     <= tx_done_d;
`ifdef IIITB_UART_TX_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef IIITB_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.tx_Enable && !bus.sig_Empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = bus.buffer_Output;
`ifdef IIITB_UART_TX_PARITY_EN
                parity_d = ^bus.buffer_Output;
`endif
                state_d = START;
            end
            START: begin
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef IIITB_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef IIITB_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        read_enable_d = (state_d == POP);
        tx_busy_d     = (state_d != IDLE);
        tx_done_d     = (state_d == STOP) && baud_tick_pre;
        case (state_d)
            START:   tx_serial_d = 1'b0;
            DATA:    tx_serial_d = shift_d[0];
`ifdef IIITB_UART_TX_PARITY_EN
            PARITY:  tx_serial_d = parity_d;
`endif
            default: tx_serial_d = LINE_IDLE;
        endcase
    end

    assign bus.read_Enable = read_enable_q;
    assign bus.tx_Serial   = tx_serial_q;
    assign bus.tx_Busy     = tx_busy_q;
    assign bus.tx_Done     = tx_done_q;

endmodule
